// File: rtl/main_host_pkg.sv
// Shared types and constants for the bsort100 host sequencer.
package main_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_READ,
    ST_FIN
  } state_t;

  localparam int WORD_W = 32;
  localparam int SIZE32 = 32;
  localparam int CH0    = 0;
  localparam int CH1    = 1;

endpackage

// File: rtl/slave_port_ch.sv
// One slave RAM channel with a single outstanding access; enables rise the cycle after req.
// Enables and fields hold until data_rdy, then drop the following cycle; req is ignored while pend.
module slave_port_ch
  import main_host_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              pend,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              oe,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [SIZE_W-1:0] size,
  input  logic              data_rdy,
  input  logic [DATA_W-1:0] rdata_in
);

  logic we_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend  <= 1'b0;
      we_r  <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      size  <= '0;
    end else if (!pend && req) begin
      pend  <= 1'b1;
      we_r  <= req_we;
      addr  <= req_addr;
      wdata <= req_wdata;
      size  <= SIZE_W'(SIZE32);
    end else if (pend && data_rdy) begin
      pend <= 1'b0;
    end
  end

  // A ready strobe with nothing outstanding never reaches the sequencer.
  assign ack   = pend & data_rdy;
  assign oe    = pend & ~we_r;
  assign we    = pend & we_r;
  assign rdata = rdata_in;

endmodule

// File: rtl/main_host_sequencer.sv
// Loads the array into `main`, runs it timing start->done, reads results back and checks order.
// Each element waits out_ready before the next read issues, so backpressure stalls the memory.
module main_host_sequencer
  import main_host_pkg::*;
#(
  parameter int N_WORDS     = 100,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 64,
  parameter int SIZE_W      = 7,
  parameter int TIMEOUT_CYC = 200000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic                out_last,
  output logic                busy,
  output logic                seq_done,
  output logic                timeout,
  output logic                sorted_ok,
  output logic [31:0]         cycles,
  output logic                start_port,
  input  logic                done_port,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [2*DATA_W-1:0] S_Wdata_ram,
  output logic [2*SIZE_W-1:0] S_data_ram_size,
  input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy
);

  localparam logic [31:0] LAST_IDX    = 32'(N_WORDS - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);

  state_t            state, state_nxt;
  logic [31:0]       idx, counter, prev, byte_addr, rd_word;
  logic              req, req_we, pend, ack;
  logic              ch0_oe, ch0_we;
  logic [ADDR_W-1:0] ch0_addr;
  logic [DATA_W-1:0] ch0_wdata, ch0_rdata;
  logic [SIZE_W-1:0] ch0_size;
  logic              unused_ok;

  assign byte_addr = 32'(BASE_ADDR) + {idx[29:0], 2'b00};
  assign rd_word   = ch0_rdata[WORD_W-1:0];
  assign unused_ok = ^{byte_addr[31:ADDR_W], idx[31:30], ch0_rdata[DATA_W-1:WORD_W],
                       Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[CH1]};

  slave_port_ch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) u_ch0 (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (byte_addr[ADDR_W-1:0]),
    .req_wdata (DATA_W'(in_data)),
    .pend      (pend),
    .ack       (ack),
    .rdata     (ch0_rdata),
    .oe        (ch0_oe),
    .we        (ch0_we),
    .addr      (ch0_addr),
    .wdata     (ch0_wdata),
    .size      (ch0_size),
    .data_rdy  (Sout_DataRdy[CH0]),
    .rdata_in  (Sout_Rdata_ram[DATA_W-1:0])
  );

  // Channel 1 is never driven.
  assign S_oe_ram        = {1'b0, ch0_oe};
  assign S_we_ram        = {1'b0, ch0_we};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, ch0_addr};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, ch0_wdata};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, ch0_size};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    start_port = 1'b0;
    seq_done   = 1'b0;
    req        = 1'b0;
    req_we     = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (go) state_nxt = ST_LOAD;
      ST_LOAD: begin
        in_ready = !pend;
        req      = in_valid && !pend;
        req_we   = 1'b1;
        if (ack && idx == LAST_IDX) state_nxt = ST_START;
      end
      ST_START: begin
        start_port = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_RUN: begin
        if (done_port)                 state_nxt = ST_READ;
        else if (counter >= TIMEOUT_LIM) state_nxt = ST_FIN;
      end
      ST_READ: begin
        req = !pend && !out_valid;
        if (out_valid && out_ready && idx == LAST_IDX) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        seq_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      counter   <= '0;
      cycles    <= '0;
      timeout   <= 1'b0;
      sorted_ok <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      prev      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          idx       <= '0;
          timeout   <= 1'b0;
          sorted_ok <= 1'b0;
        end
        ST_LOAD: if (ack) begin
          idx <= (idx == LAST_IDX) ? '0 : idx + 32'd1;
          // The start_port cycle itself counts as cycle 1 of the latency.
          if (idx == LAST_IDX) counter <= 32'd1;
        end
        ST_START: counter <= counter + 32'd1;
        ST_RUN: begin
          counter <= counter + 32'd1;
          if (done_port) begin
            cycles    <= counter;
            sorted_ok <= 1'b1;
            idx       <= '0;
          end else if (counter >= TIMEOUT_LIM) begin
            timeout <= 1'b1;
          end
        end
        ST_READ: begin
          if (ack) begin
            out_data  <= rd_word;
            out_valid <= 1'b1;
            prev      <= rd_word;
            if (idx != '0 && $signed(rd_word) < $signed(prev)) sorted_ok <= 1'b0;
          end
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            idx       <= idx + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_last = out_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_main_host_sequencer.sv
// Bench for main_host_sequencer with a 4-word configuration, a slave RAM model and a sorting core model.
module tb_main_host_sequencer;

  localparam int NW = 4;
  localparam int TO = 50;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         go = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_ready, out_valid, out_last, busy, seq_done, timeout, sorted_ok, start_port;
  logic [31:0]  out_data, cycles;
  logic         done_port;
  logic [1:0]   S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [19:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [13:0]  S_data_ram_size;

  always #5 clock = ~clock;

  main_host_sequencer #(.N_WORDS(NW), .BASE_ADDR(0), .ADDR_W(10), .DATA_W(64),
                        .SIZE_W(7), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .go(go), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .seq_done(seq_done), .timeout(timeout),
    .sorted_ok(sorted_ok), .cycles(cycles), .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  function automatic logic [3:0][31:0] pk(input int a0, input int a1, input int a2, input int a3);
    pk[0] = a0; pk[1] = a1; pk[2] = a2; pk[3] = a3;
  endfunction

  function automatic logic [3:0][31:0] sort4(input logic [3:0][31:0] a);
    logic [31:0] t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if ($signed(a[j]) > $signed(a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a;
  endfunction

  // Slave RAM (write ready after 1 cycle, read after 2) plus core (done 10 cycles after start).
  logic [31:0]      mem [0:255];
  logic [3:0][31:0] srt;
  logic             rdy0 = 1'b0, ch1_bad = 1'b0;
  logic             core_done_en = 1'b1, core_sort_en = 1'b1;
  logic [63:0]      rd0 = '0;
  logic [3:0]       dcnt = '0;
  int               mcnt = 0, start_cnt = 0, wr_n = 0;
  logic [9:0]       wr_addr [64];
  logic [31:0]      wr_dat [64];
  logic [6:0]       wr_size [64];

  assign srt            = sort4({mem[3], mem[2], mem[1], mem[0]});
  assign Sout_DataRdy   = {1'b0, rdy0};
  assign Sout_Rdata_ram = {64'hFFFF_0000_FFFF_0000, rd0};
  assign done_port      = (dcnt == 4'd1);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy0 <= 1'b0; mcnt <= 0; dcnt <= '0;
    end else begin
      if (rdy0) rdy0 <= 1'b0;
      else if (S_we_ram[0] || S_oe_ram[0]) begin
        if (mcnt + 1 >= (S_we_ram[0] ? 1 : 2)) begin
          rdy0 <= 1'b1; mcnt <= 0;
          if (S_we_ram[0]) begin
            mem[S_addr_ram[9:2]] <= S_Wdata_ram[31:0];
            wr_addr[wr_n % 64]   <= S_addr_ram[9:0];
            wr_dat[wr_n % 64]    <= S_Wdata_ram[31:0];
            wr_size[wr_n % 64]   <= S_data_ram_size[6:0];
            wr_n                 <= wr_n + 1;
          end else rd0 <= {32'hA5A5_5A5A, mem[S_addr_ram[9:2]]};
        end else mcnt <= mcnt + 1;
      end
      if (start_port) begin
        start_cnt <= start_cnt + 1;
        if (core_done_en) dcnt <= 4'd10;
        if (core_sort_en) for (int i = 0; i < 4; i++) mem[i] <= srt[i];
      end else if (dcnt != 0) dcnt <= dcnt - 4'd1;
      if (S_oe_ram[1] || S_we_ram[1] || (|S_addr_ram[19:10]) || (|S_Wdata_ram[127:32]) ||
          (|S_data_ram_size[13:7])) ch1_bad <= 1'b1;
    end
  end

  typedef struct packed {
    logic [3:0][31:0] in_v;
    logic [3:0][31:0] exp_v;
    logic             sort_en;
    logic             exp_sorted;
    logic             stall;
  } vec_t;

  vec_t vecs [4];
  int   n_checks = 0, n_err = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input int v);
    int k = 0, j = 0, stall_n = 0, st0 = start_cnt, wb = wr_n;
    bit in_hs = 0, out_hs = 0, seen = 0, done = 0;
    core_sort_en = vecs[v].sort_en; core_done_en = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock); go = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clock);
      go = (c == 6);                      // a go while busy must be ignored
      if (in_hs) k++;
      if (out_hs) begin j++; seen = 0; end
      in_valid = (k < NW);
      in_data  = vecs[v].in_v[(k < NW) ? k : 0];
      in_hs    = in_valid && in_ready;
      out_ready = 1'b1;
      if (out_valid) begin
        if (!seen) begin
          check($sformatf("v%0d out_data[%0d]", v, j), out_data, vecs[v].exp_v[j]);
          check($sformatf("v%0d out_last[%0d]", v, j), out_last, (j == NW - 1));
          seen = 1;
        end
        if (vecs[v].stall && j == 1 && stall_n < 5) begin
          out_ready = 1'b0; stall_n++;
          check($sformatf("v%0d stall data", v), out_data, vecs[v].exp_v[1]);
          check($sformatf("v%0d stall oe", v), S_oe_ram[0], 1'b0);
        end
      end
      out_hs = out_valid && out_ready;
      if (seq_done) begin
        done = 1;
        check($sformatf("v%0d sorted_ok", v), sorted_ok, vecs[v].exp_sorted);
        check($sformatf("v%0d cycles", v), cycles, 32'd11);
        check($sformatf("v%0d timeout", v), timeout, 1'b0);
        check($sformatf("v%0d n_out", v), j, NW);
      end
    end
    if (!done) check($sformatf("v%0d seq_done seen", v), 1'b0, 1'b1);
    go = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d seq_done pulse", v), seq_done, 1'b0);
    check($sformatf("v%0d busy after", v), busy, 1'b0);
    check($sformatf("v%0d start pulses", v), start_cnt - st0, 1);
    check($sformatf("v%0d writes", v), wr_n - wb, NW);
    if (vecs[v].stall) check($sformatf("v%0d stall cycles", v), stall_n, 5);
    for (int w = 0; w < NW; w++) begin
      check($sformatf("v%0d wr_addr[%0d]", v, w), wr_addr[(wb + w) % 64], 10'(4 * w));
      check($sformatf("v%0d wr_dat[%0d]", v, w), wr_dat[(wb + w) % 64], vecs[v].in_v[w]);
      check($sformatf("v%0d wr_size[%0d]", v, w), wr_size[(wb + w) % 64], 7'd32);
    end
    check($sformatf("v%0d ch1 idle", v), ch1_bad, 1'b0);
  endtask

  initial begin
    int  k, cs, cd, ov;
    bit  in_hs, found;

    vecs[0] = '{in_v: pk(5, -1, 3, 2), exp_v: pk(-1, 2, 3, 5), sort_en: 1'b1, exp_sorted: 1'b1, stall: 1'b0};
    vecs[1] = '{in_v: pk(5, -1, 3, 2), exp_v: pk(5, -1, 3, 2), sort_en: 1'b0, exp_sorted: 1'b0, stall: 1'b1};
    vecs[2] = '{in_v: pk(7, 7, -8, 100), exp_v: pk(-8, 7, 7, 100), sort_en: 1'b1, exp_sorted: 1'b1, stall: 1'b0};
    vecs[3] = '{in_v: pk(1, 2, 3, 32'h8000_0000), exp_v: pk(1, 2, 3, 32'h8000_0000),
                sort_en: 1'b0, exp_sorted: 1'b0, stall: 1'b0};

    repeat (2) @(negedge clock);
    check("rst outputs", {in_ready, out_valid, out_last, busy, seq_done, timeout, sorted_ok, start_port}, 8'h00);
    check("rst out_data", out_data, 32'd0);
    check("rst cycles", cycles, 32'd0);
    check("rst slave en", {S_oe_ram, S_we_ram}, 4'h0);
    check("rst slave fields", {S_addr_ram, S_Wdata_ram, S_data_ram_size}, '0);
    reset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Core never finishes: run must time out with no readback.
    core_done_en = 1'b0; core_sort_en = 1'b0;
    k = 0; in_hs = 0; cs = -1; cd = -1; ov = 0;
    go = 1'b1;
    for (int c = 0; c < 300 && cd < 0; c++) begin
      @(negedge clock);
      go = 1'b0;
      if (in_hs) k++;
      in_valid = (k < NW);
      in_data  = vecs[0].in_v[(k < NW) ? k : 0];
      in_hs    = in_valid && in_ready;
      if (out_valid) ov++;
      if (start_port) cs = c;
      if (cs >= 0 && c == cs + 40) check("timeout early", timeout, 1'b0);
      if (seq_done) begin
        cd = c;
        check("timeout set", timeout, 1'b1);
        check("timeout sorted_ok", sorted_ok, 1'b0);
      end
    end
    check("timeout seq_done seen", cd >= 0, 1'b1);
    check("timeout no out_valid", ov, 0);
    check("timeout run length", (cs >= 0) && (cd - cs >= 49) && (cd - cs <= 52), 1'b1);
    @(negedge clock);
    check("timeout sticky", timeout, 1'b1);
    run_vec(0);

    // Reset while the third element's write is outstanding.
    core_done_en = 1'b1;
    k = 0; in_hs = 0; found = 0;
    go = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clock);
      go = 1'b0;
      if (S_we_ram[0] && S_addr_ram[9:0] == 10'd8) found = 1;
      else begin
        if (in_hs) k++;
        in_valid = (k < NW);
        in_data  = vecs[0].in_v[(k < NW) ? k : 0];
        in_hs    = in_valid && in_ready;
      end
    end
    check("mid-load write seen", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort enables", {S_oe_ram, S_we_ram, start_port}, 5'h00);
    check("abort outputs", {busy, in_ready, out_valid, seq_done}, 4'h0);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/main_host_sequencer.md
Name: main_host_sequencer

Overview:
- Synthesizable host-side driver for the HLS-generated accelerator core (bsort100 `main`).
- Preloads the input array into the core's internal memory through its two-channel slave RAM port, pulses start_port and measures latency until done_port.
- Reads the result array back, streams it out and flags whether it is ascending.
- Sits directly upstream and downstream of `main`, in place of the simulation-only stimulus driver.

Parameters:
- N_WORDS, 100, number of 32-bit elements loaded and read back.
- BASE_ADDR, 0, byte address of element 0 in the core's memory.
- ADDR_W, 10, per-channel slave address width (S_addr_ram is 2*ADDR_W).
- DATA_W, 64, per-channel slave data width (S_Wdata_ram and Sout_Rdata_ram are 2*DATA_W).
- SIZE_W, 7, per-channel access-size field width.
- TIMEOUT_CYC, 200000000, run-phase cycle limit.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  start one load/run/readback sequence; sampled in IDLE only.
- in_valid  in  1  input element valid.
- in_ready  out  1  input element accepted.
- in_data  in  32  input element, element 0 first.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  result element.
- out_last  out  1  marks element N_WORDS-1.
- busy  out  1  sequence in progress.
- seq_done  out  1  one-cycle pulse at sequence end.
- timeout  out  1  sticky; run exceeded TIMEOUT_CYC.
- sorted_ok  out  1  valid at seq_done; results non-decreasing (signed).
- cycles  out  32  latency of the last run.
- start_port  out  1  to core.
- done_port  in  1  from core.
- S_oe_ram  out  2  slave read enable per channel.
- S_we_ram  out  2  slave write enable per channel.
- S_addr_ram  out  2*ADDR_W  slave address.
- S_Wdata_ram  out  2*DATA_W  slave write data.
- S_data_ram_size  out  2*SIZE_W  access size in bits.
- Sout_Rdata_ram  in  2*DATA_W  slave read data.
- Sout_DataRdy  in  2  slave access complete per channel.

Behaviour:
- Reset (async assert, sync release) values:
  - all outputs 0;
  - cycles = 0, sorted_ok = 0, timeout = 0;
  - FSM in IDLE.
- Slave access rules:
  - Only channel 0 is used. Channel 1 fields are held at 0 at all times.
  - Address = BASE_ADDR + 4*i, truncated to ADDR_W. Size = 32. Write data is zero-extended.
  - One access is outstanding at a time.
  - oe/we is held high with stable address and data until the cycle Sout_DataRdy[0]=1, then drops in the next cycle.
  - The next access may begin the cycle after the drop.
  - DataRdy seen while no access is outstanding is ignored.
- States:
  - IDLE: go=1 -> LOAD; clears element index, timeout and sorted_ok.
  - LOAD:
    - in_ready=1 while no write is outstanding;
    - in_valid&in_ready captures in_data and issues the write;
    - on DataRdy, index++;
    - after element N_WORDS-1 completes -> START.
  - START: start_port=1 for exactly one cycle; cycles counter set to 1 -> RUN.
  - RUN:
    - counter +1 per cycle;
    - done_port=1 latches the counter into `cycles` -> READ;
    - done_port in the START cycle is ignored;
    - counter reaching TIMEOUT_CYC sets timeout and goes to FIN; readback is skipped and no data is output.
  - READ:
    - issue read i; on DataRdy capture Sout_Rdata_ram[31:0] into the output register;
    - out_valid=1 until out_ready; out_last=1 when i=N_WORDS-1;
    - the next read issues only after the handshake, so there is no skid buffer and backpressure stalls the memory.
  - FIN: seq_done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- sorted_ok:
  - set to 1 entering READ;
  - cleared if any element is signed-less-than its predecessor;
  - unaffected by element 0;
  - final at seq_done.
- go while busy is ignored.
- A reset mid-sequence aborts immediately. start_port and all enables drop asynchronously.
- N_WORDS=1 is legal: one write, one read, out_last on the sole element.

Decomposition:
- Shared package `main_host_pkg`:
  - FSM state enum (IDLE, LOAD, START, RUN, READ, FIN);
  - slave channel field widths and slice constants;
  - SIZE32 constant (32).
- One natural sub-module: `slave_port_ch` encapsulates the single-outstanding access handshake (req/we/addr/wdata in; ack/rdata out) for one channel. The sequencer instantiates it for channel 0 only.

Test Plan:
- N_WORDS=4, inputs {5,-1,3,2}, memory model with 2-cycle read and 1-cycle write DataRdy -> 4 writes at addresses 0,4,8,12 with size 32. Exactly one start_port pulse.
- Core model asserts done_port 10 cycles after start_port -> cycles=11; readback {-1,2,3,5} gives sorted_ok=1, out_last on the 4th element, then one seq_done pulse.
- Core model leaves memory unsorted {5,-1,3,2} -> sorted_ok=0 at seq_done; all 4 values are still streamed in order.
- out_ready held low 5 cycles on element 1 -> out_data is stable and no oe is issued for element 2 until the handshake completes.
- done_port never asserted, TIMEOUT_CYC=50 -> timeout=1 after 50 run cycles; no out_valid; seq_done pulses; a following go clears timeout.
- reset driven low mid-LOAD (element 2 write pending) -> all enables and outputs are 0 within the same cycle; a subsequent go restarts at address BASE_ADDR.
